serial_rca_adder: RTL and testbench
===================================

Name: serial_rca_adder

Overview:
- Multi-cycle adder. Computes S = A + B + Cin one DIGIT-bit slice per clock.
- Each slice is a small ripple-carry chain built from half-adder cells; a registered carry links one slice to the next.
- Sits in the ALU datapath as the low-area alternative to the full-width ripple-carry adder.
- Valid/ready on both sides: it is fed by the operand stage and consumed by the result mux.

Parameters:
- WIDTH, 32: operand and result width in bits.
- DIGIT, 1: bits processed per cycle. WIDTH must be an exact multiple of DIGIT, otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A, B, Cin are valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result
- S  output  WIDTH  sum
- Cout  output  1  carry out of the MSB
- V  output  1  signed overflow
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, S=0, Cout=0, V=0, slice counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B into shift registers and Cin into the carry register, clear the counter, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, add the low DIGIT bits of A and B plus the carry register. Per bit: two half adders, with their carries ORed.
  - Write the slice sum into the top DIGIT bits of the S shift register, shifting it right by DIGIT.
  - Shift the A/B registers right by DIGIT, update the carry register, increment the counter.
  - On the slice where counter == N-1:
    - Cout = carry out of the slice MSB.
    - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- Latency: handshake at edge E0. Slices are processed at edges E1..EN. out_valid is high from after edge EN, i.e. N cycles after acceptance.
- DONE:
  - out_valid=1. S, Cout and V are stable and unchanged while out_ready=0.
  - On out_ready: out_valid drops at the next edge and the FSM returns to IDLE.
  - in_ready stays 0 in DONE, so throughput is one operation per N+2 cycles minimum.
- Inputs ignored outside IDLE: in_valid while not in IDLE is ignored, and A/B changes do not affect a running operation.
- Arithmetic: modulo 2^WIDTH, unsigned. V is the two's-complement overflow flag.
- Reset mid-operation (rst_n low in RUN or DONE): immediately returns to reset values; the partial result is discarded and no out_valid is issued.
- out_ready when out_valid=0: no effect.
- Outputs S, Cout, V hold their last value in IDLE until the next completion.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands at the IDLE handshake.
  - If sub=1: B is latched inverted and the carry register is loaded with 1, ignoring Cin, so the result is A - B.
  - Cout=1 means no borrow. V is signed subtract overflow.
- When undefined: no sub port; addition only, exactly as above.

Test Plan:
- WIDTH=32, DIGIT=1; A=0x00000005, B=0x00000003, Cin=0 -> S=0x00000008, Cout=0, V=0. out_valid rises exactly 32 cycles after the accept edge, and in_ready=0 throughout.
- A=0xFFFFFFFF, B=0x00000001, Cin=0 -> S=0x00000000, Cout=1, V=0. Then A=0x7FFFFFFF, B=0x00000000, Cin=1 -> S=0x80000000, Cout=0, V=1.
- DIGIT=4; A=0x12345678, B=0x87654321, Cin=1 -> S=0x9999999A, Cout=0. out_valid rises 8 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. S, Cout, V stay constant and in_ready stays 0. A new in_valid during this time is not accepted; it is accepted in the first IDLE cycle after out_ready.
- Reset mid-run: pulse rst_n low for 3 ns at slice 10 of a 32-slice add. All outputs go to 0 immediately, the block is in IDLE with in_ready=1 after release, and no stray out_valid appears.
- With SERIAL_ADDER_SUB_EN: sub=1, A=5, B=7 -> S=0xFFFFFFFE, Cout=0, V=0. Then sub=1, A=0x80000000, B=1 -> S=0x7FFFFFFF, Cout=1, V=1.

Source files
------------

// File: rtl/serial_rca_adder.sv
// serial_rca_adder: multi-cycle adder, S = A + B + Cin computed DIGIT bits per clock.
// Each slice is a ripple chain of half-adder pairs. A registered carry links one
// slice to the next. Valid/ready handshakes on the operand side and the result side.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that selects A - B.
module serial_rca_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  // Reject configurations where the slices do not tile the operand exactly
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_rca_adder: WIDTH must be an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] ha1_s, ha1_c, ha2_c;
  logic [DIGIT-1:0] slice_sum;
  logic [WIDTH-1:0] acc_shift;
  logic             accept;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Slice adder: per bit two half adders, their carries ORed into the next bit
  always_comb begin
    chain_c    = '0;
    ha1_s      = '0;
    ha1_c      = '0;
    ha2_c      = '0;
    slice_sum  = '0;
    chain_c[0] = carry_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      ha1_s[i]       = a_q[i] ^ b_q[i];
      ha1_c[i]       = a_q[i] & b_q[i];
      slice_sum[i]   = ha1_s[i] ^ chain_c[i];
      ha2_c[i]       = ha1_s[i] & chain_c[i];
      chain_c[i + 1] = ha1_c[i] | ha2_c[i];
    end
  end

  // New slice enters at the top of the accumulator as older slices move down
  always_comb begin
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
  end

  // Operand conditioning at the handshake (inverted B and forced carry for subtract)
  always_comb begin
    accept = in_valid & in_ready_q & (state_q == ST_IDLE);
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~B : B;
    carry_load = sub ? 1'b1 : Cin;
`else
    b_load     = B;
    carry_load = Cin;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    cout_d      = cout_q;
    v_d         = v_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = A;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = chain_c[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          s_d     = acc_shift;
          cout_d  = chain_c[DIGIT];
          v_d     = chain_c[DIGIT] ^ chain_c[DIGIT-1];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_serial_rca_adder.sv
// Bench for serial_rca_adder: a DIGIT=1 and a DIGIT=4 instance share the same stimulus,
// a transaction-level model predicts every output every cycle, and directed cases pin
// literal results and latencies.
module tb_serial_rca_adder;

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        Cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub = 1'b0;
`endif

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic        cout_w      [2];
  logic        v_w         [2];
  logic        busy_w      [2];
  logic [31:0] s_w         [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_rca_adder #(.WIDTH(32), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .S(s_w[0]),
    .Cout(cout_w[0]), .V(v_w[0]), .busy(busy_w[0])
  );

  serial_rca_adder #(.WIDTH(32), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .S(s_w[1]),
    .Cout(cout_w[1]), .V(v_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {V, Cout, S}
  function automatic logic [33:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sb);
    logic [31:0] bx;
    logic        c0;
    logic [32:0] t;
    logic        v;
    bx = sb ? ~b : b;
    c0 = sb ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, bx} + 33'(c0);
    v  = (a[31] == bx[31]) && (t[31] != a[31]);
    return {v, t};
  endfunction

  function automatic int slices(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  // Transaction model: phase, remaining slices and held results per instance
  int          m_state [2];
  int          m_left  [2];
  logic [33:0] m_pend  [2];
  logic [31:0] m_s     [2];
  logic        m_c     [2];
  logic        m_v     [2];

  always @(posedge clk or negedge rst_n) begin
    logic sb;
`ifdef SERIAL_ADDER_SUB_EN
    sb = sub;
`else
    sb = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_state[d] = MI;
        m_left[d]  = 0;
        m_pend[d]  = '0;
        m_s[d]     = '0;
        m_c[d]     = 1'b0;
        m_v[d]     = 1'b0;
      end else begin
        case (m_state[d])
          MI: if (in_valid) begin
            m_pend[d]  = ref_sum(A, B, Cin, sb);
            m_left[d]  = slices(d);
            m_state[d] = MR;
          end
          MR: begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
              m_state[d] = MD;
              m_s[d]     = m_pend[d][31:0];
              m_c[d]     = m_pend[d][32];
              m_v[d]     = m_pend[d][33];
            end
          end
          default: if (out_ready) m_state[d] = MI;
        endcase
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("in_ready",  d, 32'(in_ready_w[d]),  32'(m_state[d] == MI));
        chk("busy",      d, 32'(busy_w[d]),      32'(m_state[d] == MR));
        chk("out_valid", d, 32'(out_valid_w[d]), 32'(m_state[d] == MD));
        chk("S",         d, s_w[d],              m_s[d]);
        chk("Cout",      d, 32'(cout_w[d]),      32'(m_c[d]));
        chk("V",         d, 32'(v_w[d]),         32'(m_v[d]));
      end
    end
  end

  // One operation through both instances with out_ready held high; pins results and latency
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [31:0] es, input logic ec, input logic ev);
    int seen [2];
    bit ir_bad;
    seen   = '{0, 0};
    ir_bad = 1'b0;
    @(negedge clk);
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (seen[d] == 0 && out_valid_w[d] === 1'b1) begin
          seen[d] = k;
          chk("op_S",       d, s_w[d], es);
          chk("op_Cout",    d, 32'(cout_w[d]), 32'(ec));
          chk("op_V",       d, 32'(v_w[d]), 32'(ev));
          chk("model_S",    d, m_s[d], es);
          chk("model_Cout", d, 32'(m_c[d]), 32'(ec));
        end
      end
      if (seen[0] == 0 && in_ready_w[0] !== 1'b0) ir_bad = 1'b1;
      if (seen[0] != 0) break;
    end
    chk("latency_d1", 0, 32'(seen[0]), 32'd32);
    chk("latency_d4", 1, 32'(seen[1]), 32'd8);
    chk("in_ready_low_during_run", 0, 32'(ir_bad), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int d);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid_w[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_out_valid", d, 32'(got), 32'd1);
  endtask

  initial begin
    int stray;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready",  d, 32'(in_ready_w[d]),  32'd1);
      chk("rst_out_valid", d, 32'(out_valid_w[d]), 32'd0);
      chk("rst_busy",      d, 32'(busy_w[d]),      32'd0);
      chk("rst_S",         d, s_w[d],              32'd0);
      chk("rst_Cout",      d, 32'(cout_w[d]),      32'd0);
      chk("rst_V",         d, 32'(v_w[d]),         32'd0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    do_op(32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    // Backpressure: results held, new request refused until the consumer takes the result
    @(negedge clk);
    A = 32'h0000_FFFF; B = 32'h0000_0001; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(0);
    @(negedge clk);
    A = 32'h0000_0001; B = 32'h0000_0002; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("bp_S",         d, s_w[d], 32'h0001_0000);
        chk("bp_in_ready",  d, 32'(in_ready_w[d]), 32'd0);
        chk("bp_out_valid", d, 32'(out_valid_w[d]), 32'd1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 0, 32'(out_valid_w[0]), 32'd0);
    chk("bp_release_ready", 0, 32'(in_ready_w[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_accept_busy", 0, 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(0);
    chk("bp_next_S", 0, s_w[0], 32'h0000_0003);
    repeat (2) @(negedge clk);

    // Reset in the middle of a run
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; Cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_in_ready",  d, 32'(in_ready_w[d]),  32'd1);
      chk("mid_rst_out_valid", d, 32'(out_valid_w[d]), 32'd0);
      chk("mid_rst_busy",      d, 32'(busy_w[d]),      32'd0);
      chk("mid_rst_S",         d, s_w[d],              32'd0);
      chk("mid_rst_Cout",      d, 32'(cout_w[d]),      32'd0);
      chk("mid_rst_V",         d, 32'(v_w[d]),         32'd0);
    end
    #2 rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_w[0] !== 1'b0 || out_valid_w[1] !== 1'b0) stray++;
    end
    chk("no_stray_out_valid", 0, 32'(stray), 32'd0);
    chk("idle_after_reset",   0, 32'(in_ready_w[0]), 32'd1);

    // Random traffic with random backpressure, checked every cycle by the model
    repeat (2500) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      Cin       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       A = 32'hFFFF_FFFF;
        1:       A = 32'h7FFF_FFFF;
        2:       A = 32'h8000_0000;
        default: A = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       B = 32'hFFFF_FFFF;
        1:       B = 32'h0000_0000;
        2:       B = 32'h8000_0000;
        default: B = $urandom;
      endcase
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
